// File: rtl/inst_prefetch_mem_pkg.sv
// Shared widths, queue entry layout and constants for the instruction prefetch memory.
package inst_prefetch_mem_pkg;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned PC_W       = 32;

  localparam logic [DEF_DATA_W-1:0] NOP = 32'h0;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [PC_W-1:0]       pc;
    logic                  fault;
  } entry_t;
endpackage

// File: rtl/inst_prefetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; the producer guarantees it never overflows.
module inst_prefetch_fifo #(
  parameter  int unsigned W     = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic [W-1:0]     o_head,
  output logic [CNT_W-1:0] o_count
);
  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage is cleared on reset so the head reads as all-zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/inst_prefetch_mem.sv
// Instruction memory with autonomous fetch counter, 1-cycle read and a prefetch queue toward decode.
module inst_prefetch_mem
  import inst_prefetch_mem_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned RESET_PC      = 0,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_fault
);
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned ENTRY_W = DATA_W + PC_W + 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    r_rd_pc;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_fault;
  logic               r_inflight;
  logic               r_halted;

  logic [CNT_W-1:0]   w_count;
  logic               w_in_range;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_push_entry;
  logic [ENTRY_W-1:0] w_head;

  assign w_in_range = (r_fetch_pc >> ADDR_W) == '0;

  // Queue slots already promised to in-flight reads are counted; a same-cycle pop is not.
  assign w_issue = fetch_en && !r_halted && !redirect_valid &&
                   ((32'(w_count) + 32'(r_inflight)) < FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= PC_W'(RESET_PC);
      r_rd_pc    <= '0;
      r_rd_fault <= 1'b0;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(1);
        r_rd_pc    <= r_fetch_pc;
        r_rd_fault <= !w_in_range;
        if (!w_in_range) r_halted <= 1'b1;
      end
    end
  end

  // Read-first: a load to the address being read lands after the old word is captured.
  always_ff @(posedge clk) begin
    if (!rst && load_en) r_mem[load_addr] <= load_data;
    if (w_issue && w_in_range) r_rd_data <= r_mem[r_fetch_pc[ADDR_W-1:0]];
  end

  assign w_push       = r_inflight && !redirect_valid;
  assign w_pop        = inst_valid && inst_ready && !redirect_valid;
  assign w_push_entry = {(r_rd_fault ? DATA_W'(NOP) : r_rd_data), r_rd_pc, r_rd_fault};

  inst_prefetch_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign inst_valid                        = (w_count != '0);
  assign {inst_data, inst_pc, inst_fault}  = w_head;
endmodule

// File: tb/tb_inst_prefetch_mem.sv
// Scoreboard bench for inst_prefetch_mem: expected entries queued at stimulus time, checked as decode consumes them.
module tb_inst_prefetch_mem;
  import inst_prefetch_mem_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk            = 1'b0;
  logic          rst            = 1'b1;
  logic          fetch_en       = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc    = '0;
  logic          load_en        = 1'b0;
  logic [AW-1:0] load_addr      = '0;
  logic [31:0]   load_data      = '0;
  logic          inst_ready     = 1'b0;
  logic          inst_valid;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;
  logic          inst_fault;

  int vectors     = 0;
  int miscompares = 0;

  entry_t      sb [$];
  logic [31:0] shadow [DEPTH];

  inst_prefetch_mem dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  function automatic entry_t exp_of(input logic [31:0] pc);
    entry_t e;
    e.pc    = pc;
    e.fault = (pc >= DEPTH);
    e.data  = e.fault ? NOP : shadow[pc[AW-1:0]];
    return e;
  endfunction

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    shadow[a] = d;
  endtask

  // Pulses a redirect; returns at the falling edge just after the redirect edge.
  task automatic redirect_to(input logic [31:0] pc);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    sb.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({inst_valid, inst_data, inst_pc, inst_fault} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b data=%h pc=%h fault=%b, want all zero",
               inst_valid, inst_data, inst_pc, inst_fault);
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) load_word(AW'(i), 32'h10 + 32'(i));
    for (int i = 100; i < 108; i++) load_word(AW'(i), 32'hC0DE_0000 | 32'(i));
    for (int i = 1016; i < 1024; i++) load_word(AW'(i), 32'hF000_0000 | 32'(i));
    load_word(AW'(200), 32'hAAAA_0200);
    @(negedge clk);
    load_en = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_disabled: got valid=%b, want 0", inst_valid);
    end
  endtask

  task automatic test_stream();
    entry_t e;
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) sb.push_back(exp_of(32'(i)));
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_first_latency: got valid=%b after edge 1, want 0", inst_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (!inst_valid || sb.size() == 0) begin
        miscompares++;
        $display("FAIL stream[%0d]: got valid=%b, want 1 (no bubble)", i, inst_valid);
      end else begin
        e = sb.pop_front();
        if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
          miscompares++;
          $display("FAIL stream[%0d]: got pc=%0d data=%h fault=%b, want pc=%0d data=%h fault=%b",
                   i, inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    entry_t e;
    inst_ready = 1'b0;
    redirect_to(32'd0);
    for (int i = 0; i < 12; i++) sb.push_back(exp_of(32'(i)));
    repeat (10) @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin
      miscompares++;
      $display("FAIL stall_head: got valid=%b pc=%0d, want valid=1 pc=0", inst_valid, inst_pc);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (!inst_valid || sb.size() == 0) begin
        miscompares++;
        $display("FAIL drain[%0d]: got valid=%b, want 1", i, inst_valid);
      end else begin
        e = sb.pop_front();
        if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
          miscompares++;
          $display("FAIL drain[%0d]: got pc=%0d data=%h fault=%b, want pc=%0d data=%h fault=%b",
                   i, inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
        end
      end
    end
  endtask

  task automatic test_redirect();
    entry_t e;
    bit found = 1'b0;
    inst_ready = 1'b1;
    redirect_to(32'd0);
    for (int i = 0; i < 6; i++) sb.push_back(exp_of(32'(i)));
    for (int c = 0; c < 20 && !found; c++) begin
      if (c > 0) @(negedge clk);
      if (inst_valid && inst_pc == 32'd5) found = 1'b1;
      else if (inst_valid && sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
          miscompares++;
          $display("FAIL pre_redirect: got pc=%0d data=%h, want pc=%0d data=%h",
                   inst_pc, inst_data, e.pc, e.data);
        end
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL redirect_wait: got no head at pc 5 within 20 cycles, want pc 5");
      return;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'd100;
    sb.delete();
    sb.push_back(exp_of(32'd100));
    sb.push_back(exp_of(32'd101));
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL redirect_gap[%0d]: got valid=%b pc=%0d, want valid=0", k, inst_valid, inst_pc);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (inst_valid !== 1'b1 || {inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
        miscompares++;
        $display("FAIL redirect_target[%0d]: got valid=%b pc=%0d data=%h, want valid=1 pc=%0d data=%h",
                 k, inst_valid, inst_pc, inst_data, e.pc, e.data);
      end
    end
  endtask

  task automatic test_out_of_range();
    entry_t e;
    inst_ready = 1'b1;
    redirect_to(32'd1022);
    for (int i = 1022; i < 1025; i++) sb.push_back(exp_of(32'(i)));
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (inst_valid !== 1'b1 || {inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
        miscompares++;
        $display("FAIL range[%0d]: got valid=%b pc=%0d data=%h fault=%b, want valid=1 pc=%0d data=%h fault=%b",
                 k, inst_valid, inst_pc, inst_data, inst_fault, e.pc, e.data, e.fault);
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL halted[%0d]: got valid=%b pc=%0d, want valid=0", k, inst_valid, inst_pc);
      end
    end
    redirect_to(32'd0);
    e = exp_of(32'd0);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b1 || {inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
      miscompares++;
      $display("FAIL resume_after_halt: got valid=%b pc=%0d data=%h, want valid=1 pc=0 data=%h",
               inst_valid, inst_pc, inst_data, e.data);
    end
  endtask

  task automatic test_load_collision();
    entry_t e;
    inst_ready = 1'b1;
    redirect_to(32'd0);
    for (int i = 0; i < 6; i++) sb.push_back(exp_of(32'(i)));
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 3) begin
        load_en = 1'b1; load_addr = AW'(3); load_data = 32'hDEAD_BEEF;
      end else begin
        load_en = 1'b0;
      end
      if (inst_valid && sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
          miscompares++;
          $display("FAIL read_first: got pc=%0d data=%h, want pc=%0d data=%h",
                   inst_pc, inst_data, e.pc, e.data);
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL read_first_count: got %0d entries unconsumed, want 0", sb.size());
    end
    shadow[3] = 32'hDEAD_BEEF;
    redirect_to(32'd3);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'd3 || inst_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL load_visible: got valid=%b pc=%0d data=%h, want valid=1 pc=3 data=deadbeef",
               inst_valid, inst_pc, inst_data);
    end
  endtask

  task automatic test_fetch_en();
    entry_t e;
    inst_ready = 1'b0;
    fetch_en   = 1'b1;
    redirect_to(32'd8);
    @(negedge clk);
    fetch_en = 1'b0;
    repeat (5) @(negedge clk);
    e = exp_of(32'd8);
    inst_ready = 1'b1;
    vectors++;
    if (inst_valid !== 1'b1 || {inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
      miscompares++;
      $display("FAIL inflight_completes: got valid=%b pc=%0d data=%h, want valid=1 pc=8 data=%h",
               inst_valid, inst_pc, inst_data, e.data);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_gated[%0d]: got valid=%b pc=%0d, want valid=0", k, inst_valid, inst_pc);
      end
    end
    fetch_en = 1'b1;
  endtask

  task automatic test_reset_midstream();
    entry_t e;
    inst_ready = 1'b0;
    redirect_to(32'd0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    load_en = 1'b1; load_addr = AW'(200); load_data = 32'hBBBB_0200;
    sb.delete();
    @(negedge clk);
    rst = 1'b0; load_en = 1'b0; inst_ready = 1'b1;
    vectors++;
    if ({inst_valid, inst_data, inst_pc, inst_fault} !== 66'd0) begin
      miscompares++;
      $display("FAIL midstream_reset: got valid=%b data=%h pc=%h fault=%b, want all zero",
               inst_valid, inst_data, inst_pc, inst_fault);
    end
    for (int i = 0; i < 6; i++) sb.push_back(exp_of(32'(i)));
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_latency: got valid=%b after edge 1, want 0", inst_valid);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (!inst_valid || sb.size() == 0) begin
        miscompares++;
        $display("FAIL restart[%0d]: got valid=%b, want 1", i, inst_valid);
      end else begin
        e = sb.pop_front();
        if ({inst_pc, inst_data, inst_fault} !== {e.pc, e.data, e.fault}) begin
          miscompares++;
          $display("FAIL restart[%0d]: got pc=%0d data=%h, want pc=%0d data=%h",
                   i, inst_pc, inst_data, e.pc, e.data);
        end
      end
    end
    redirect_to(32'd200);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'd200 || inst_data !== 32'hAAAA_0200) begin
      miscompares++;
      $display("FAIL load_during_reset: got valid=%b pc=%0d data=%h, want valid=1 pc=200 data=aaaa0200",
               inst_valid, inst_pc, inst_data);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_out_of_range();
    test_load_collision();
    test_fetch_en();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
